// File: rtl/xor_sched_pkg.sv
// Shared types and constants for the XOR/XNOR round-robin scheduler.
//   state_t : scheduler FSM state (IDLE -> EXEC -> RESP -> IDLE)
//   OP_XOR / OP_XNOR : per-requester operation encoding
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_XOR  = 1'b0;
  localparam logic OP_XNOR = 1'b1;

endpackage

// File: rtl/xor_rr_arb.sv
// Pure combinational round-robin arbiter.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the most recent grant; search starts just after it
//   o_grant : one-hot grant (all zero when no request)
//   o_gidx  : binary index of the granted requester
//   o_any   : at least one request is present
module xor_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_gidx,
  output logic             o_any
);

  assign o_any = |i_req;

  // Walk ptr+1, ptr+2, ... modulo N_REQ; the first hit wins. Offset N_REQ
  // comes back to ptr itself so a lone repeat requester is still served.
  always_comb begin
    int  idx;
    logic found;
    o_grant = '0;
    o_gidx  = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(i_ptr) + k) % N_REQ;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_gidx       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/xor_rr_scheduler.sv
// Time-shares one registered bitwise XOR/XNOR unit between N_REQ requesters
// with round-robin arbitration and valid/ready handshakes.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_ready  : one-hot accept strobe, asserted only in the grant cycle
//   req_op     : per-requester op (0 = XOR, 1 = XNOR)
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  : result valid, held until rsp_ready
//   rsp_ready  : consumer accepts result
//   rsp_data   : a^b or ~(a^b)
//   rsp_id     : requester that owns rsp_data
//   busy       : scheduler is in EXEC or RESP
// The reset release is expected to be synchronised to clk upstream.
module xor_rr_scheduler
  import xor_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  function automatic logic [WIDTH-1:0] f_xor_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             op
  );
    logic [WIDTH-1:0] x;
    x = a ^ b;
    return (op == OP_XNOR) ? ~x : x;
  endfunction

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;

  logic [WIDTH-1:0]   r_a_p0;
  logic [WIDTH-1:0]   r_b_p0;
  logic               r_op_p0;
  logic [IDW-1:0]     r_id_p0;

  logic [WIDTH-1:0]   r_rsp_data_p1;
  logic [IDW-1:0]     r_rsp_id_p1;
  logic               r_rsp_valid_p1;

  logic [N_REQ-1:0]   w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_any;
  logic               w_take;

  xor_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_gidx  (w_gidx),
    .o_any   (w_any)
  );

  assign w_take = (r_state == IDLE) && w_any;

  // Reset forces the state to IDLE immediately, so the strobe is also gated
  // by rst_n to keep it low while reset is held.
  assign req_ready = (w_take && rst_n) ? w_grant : '0;

  // Stage p0: operand capture in the grant cycle; later operand changes are ignored
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_a_p0  <= req_a[w_gidx*WIDTH +: WIDTH];
      r_b_p0  <= req_b[w_gidx*WIDTH +: WIDTH];
      r_op_p0 <= req_op[w_gidx];
      r_id_p0 <= w_gidx;
    end
  end

  // Stage p1: FSM, arbitration pointer and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= IDW'(N_REQ - 1);
      r_rsp_data_p1  <= '0;
      r_rsp_id_p1    <= '0;
      r_rsp_valid_p1 <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rr_ptr <= w_gidx;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data_p1  <= f_xor_op(r_a_p0, r_b_p0, r_op_p0);
          r_rsp_id_p1    <= r_id_p0;
          r_rsp_valid_p1 <= 1'b1;
          r_state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid_p1 <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_rsp_valid_p1 <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid_p1;
  assign rsp_data  = r_rsp_data_p1;
  assign rsp_id    = r_rsp_id_p1;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Self-checking bench for xor_rr_scheduler (N_REQ=4, WIDTH=8).
module tb_xor_rr_scheduler;
  import xor_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  xor_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i]       = op;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[6];

  // One isolated request with rsp_ready high: grant at T, response at T+2.
  task automatic single_op(input vec_t v, input int n);
    string tag;
    bit    got;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    set_req(v.idx, v.a, v.b, v.op);
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != '0) got = 1'b1;
    end
    chk({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << v.idx));
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    set_req(v.idx, ~v.a, v.b, ~v.op);  // must be ignored
    #1;
    chk({tag, "_t1_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_t1_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, "_t2_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_t2_data"}, 32'(rsp_data), 32'(v.exp));
    chk({tag, "_t2_id"}, 32'(rsp_id), 32'(v.idx));
    @(negedge clk);
    #1;
    chk({tag, "_t3_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_t3_busy"}, 32'(busy), 32'd0);
  endtask

  int gq[$];
  task automatic get_grants(input int n, input string tag);
    int start;
    start = gq.size();
    for (int c = 0; c < 10 * n && gq.size() < start + n; c++) begin
      @(negedge clk);
      #1;
      if (req_ready != '0) gq.push_back(oh_idx(req_ready));
    end
    chk({tag, "_count"}, 32'(gq.size() - start), 32'(n));
  endtask

  int          idq[$];
  int          overlaps;
  int          hs;
  bit          got;
  logic [7:0]  hold_d;
  logic [1:0]  hold_id;

  // reference model state for the randomized run
  bit          m_pend;
  int          m_gcyc;
  int          m_last;
  int          m_id;
  logic [7:0]  m_data;
  bit          granted[N];
  int          cyc;
  int          g;
  logic [N-1:0] exp_ready;
  bit          exp_valid;
  logic [7:0]  ma, mb;

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    vt[0] = '{0, 8'hA5, 8'h0F, OP_XOR,  8'hAA};
    vt[1] = '{2, 8'hF0, 8'hCC, OP_XNOR, 8'hC3};
    vt[2] = '{1, 8'h55, 8'h55, OP_XOR,  8'h00};
    vt[3] = '{3, 8'h55, 8'h55, OP_XNOR, 8'hFF};
    vt[4] = '{0, 8'hFF, 8'h00, OP_XNOR, 8'h00};
    vt[5] = '{3, 8'h12, 8'h34, OP_XOR,  8'h26};

    // ---- reset values, then reset asserted mid-RESP ----
    do_reset();
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    set_req(1, 8'h3C, 8'hFF, OP_XOR);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      if (rsp_valid) got = 1'b1;
    end
    chk("rstmid_reach_resp", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_data", 32'(rsp_data), 32'd0);
    chk("rstmid_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rsp_valid) hs++;
      @(negedge clk);
    end
    chk("rstmid_no_rsp", 32'(hs), 32'd0);

    // ---- table-driven single operations ----
    for (int i = 0; i < 6; i++) single_op(vt[i], i);

    // ---- fairness: all four requesting continuously ----
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 17), 8'hA0, 1'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    overlaps  = 0;
    idq.delete();
    for (int c = 0; c < 60 && idq.size() < 12; c++) begin
      @(negedge clk);
      #1;
      if ($countones(req_ready) > 1) overlaps++;
      if (rsp_valid && rsp_ready) idq.push_back(int'(rsp_id));
    end
    req_valid = '0;
    chk("fair_count", 32'(idq.size()), 32'd12);
    for (int i = 0; i < idq.size(); i++)
      chk($sformatf("fair_id%0d", i), 32'(idq[i]), 32'(i % N));
    chk("fair_overlap", 32'(overlaps), 32'd0);

    // ---- backpressure: consumer stalls 10 cycles in RESP ----
    do_reset();
    @(negedge clk);
    req_valid[1] = 1'b1;
    set_req(1, 8'h3C, 8'h0F, OP_XOR);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready[1]) got = 1'b1;
    end
    chk("bp_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b1101;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    hold_d  = 8'h33;
    hold_id = 2'd1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_data_c%0d", c), 32'(rsp_data), 32'(hold_d));
      chk($sformatf("bp_id_c%0d", c), 32'(rsp_id), 32'(hold_id));
      chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp_hold_c%0d", c), 32'(rsp_valid), 32'd1);
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rsp_valid && rsp_ready) hs++;
      @(negedge clk);
    end
    chk("bp_one_handshake", 32'(hs), 32'd1);

    // ---- wrap / skip ----
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'h00, OP_XOR);
    @(negedge clk);
    req_valid = 4'b1000;
    gq.delete();
    #1;
    if (req_ready != '0) gq.push_back(oh_idx(req_ready));
    get_grants(1 - gq.size(), "wrap_first");
    chk("wrap_g0", 32'(gq[0]), 32'd3);
    @(negedge clk);
    req_valid = 4'b1010;
    get_grants(2, "wrap_pair");
    chk("wrap_g1", 32'(gq[1]), 32'd1);
    chk("wrap_g2", 32'(gq[2]), 32'd3);
    @(negedge clk);
    req_valid = 4'b1000;
    get_grants(2, "wrap_solo");
    chk("wrap_g3", 32'(gq[3]), 32'd3);
    chk("wrap_g4", 32'(gq[4]), 32'd3);
    req_valid = '0;

    // ---- randomized run against a transaction-level model ----
    do_reset();
    m_pend = 1'b0;
    m_gcyc = 0;
    m_last = N - 1;
    m_id   = 0;
    m_data = '0;
    for (int i = 0; i < N; i++) granted[i] = 1'b0;
    cyc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (granted[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
          granted[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0;
      g = -1;
      if (!m_pend) begin
        for (int k = 1; k <= N && g < 0; k++)
          if (req_valid[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      exp_valid = m_pend && (cyc >= m_gcyc + 2);
      chk($sformatf("rnd%0d_ready", c), 32'(req_ready), 32'(exp_ready));
      chk($sformatf("rnd%0d_valid", c), 32'(rsp_valid), 32'(exp_valid));
      chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_pend));
      if (exp_valid) begin
        chk($sformatf("rnd%0d_data", c), 32'(rsp_data), 32'(m_data));
        chk($sformatf("rnd%0d_id", c), 32'(rsp_id), 32'(m_id));
      end
      if (g >= 0) begin
        ma      = req_a[g*W +: W];
        mb      = req_b[g*W +: W];
        m_data  = req_op[g] ? ~(ma ^ mb) : (ma ^ mb);
        m_id    = g;
        m_last  = g;
        m_gcyc  = cyc;
        m_pend  = 1'b1;
        granted[g] = 1'b1;
      end else if (exp_valid && rsp_ready) begin
        m_pend = 1'b0;
      end
      cyc++;
    end
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
